id_stage_segmentada: RTL and testbench
======================================

Name: id_stage_segmentada

Overview:
- Pipelined successor to the combinational decode stage: decodes one 32-bit MIPS instruction per cycle, reads the embedded register file and registers everything into an ID/EX pipeline register (1-cycle latency).
- Adds a write-first register bypass, load-use hazard detection with stall/bubble, flush on taken branch/jump, opcode-dependent sign/zero extension, branch/jump target computation and illegal-opcode flagging.
- Sits between the IF/ID register and the EX stage.

Parameters:
- len, 32, datapath and instruction width (decode field positions assume 32)
- cantidad_registros, 32, number of architectural registers
- NB_address_registros, $clog2(cantidad_registros), register address width
- NB_SENIAL_CONTROL, 8, control bundle width
- NB_ALU_OP, 2, ALU op class width
- NB_FUNCT, 6, funct field width

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_valid  in  1  i_instruccion/i_pc_plus4 hold a real instruction
- i_instruccion  in  len  instruction from IF/ID
- i_pc_plus4  in  len  PC+4 of that instruction
- i_flush  in  1  kill the instruction now in ID (taken branch/jump resolved downstream)
- i_wb_reg_write  in  1  write-back enable
- i_wb_write_reg  in  NB_address_registros  write-back address
- i_wb_write_data  in  len  write-back data
- o_stall  out  1  combinational; IF must hold PC and IF/ID this cycle
- o_valid  out  1  ID/EX holds a real instruction
- o_dato1, o_dato2  out  len  registered rs/rt operands
- o_imm  out  len  registered extended immediate
- o_rs, o_rt  out  NB_address_registros  registered source addresses (for forwarding)
- o_write_reg  out  NB_address_registros  registered destination (rd if RegDst, else rt)
- o_senial_control  out  NB_SENIAL_CONTROL  [0]RegDst [1]Jump [2]Branch [3]MemRead [4]MemtoReg [5]MemWrite [6]ALUSrc [7]RegWrite
- o_alu_op  out  NB_ALU_OP  00 add, 01 sub, 10 use o_funct, 11 reserved
- o_funct  out  NB_FUNCT  funct for EX ALU control
- o_branch_target  out  len  pc_plus4 + (sext(imm16)<<2)
- o_jump_target  out  len  {pc_plus4[31:28], instr[25:0], 2'b00}
- o_illegal  out  1  registered unknown-opcode flag

Behaviour:
- Reset (i_rst=0, asynchronous): all registers and every ID/EX output cleared to 0; o_valid=0; o_stall=0.
- Register file: $0 always reads 0 and is never written. Write occurs on the rising edge when i_wb_reg_write=1 and the address is nonzero.
- Register reads are combinational with write-first bypass: a same-cycle write to a nonzero matching address returns i_wb_write_data.
- Decode (opcode, control bits 7..0, alu_op, extension):
  - R-type 000000: 10000001, 10, none.
  - LW 100011: 11011000, 00, sign.
  - SW 101011: 01100000, 00, sign.
  - BEQ 000100: 00000100, 01, sign.
  - ADDI 001000: 11000000, 00, sign.
  - ANDI 001100: 11000000, 10, zero; o_funct forced 100100.
  - ORI 001101: 11000000, 10, zero; o_funct forced 100101.
  - J 000010: 00000010, 00, none.
  - Any other opcode: controls 0, o_illegal=1.
  - o_funct is instr[5:0] except for ANDI/ORI.
- Load-use hazard: o_stall=1 when all of the following hold:
  - i_valid and o_valid are both 1.
  - o_senial_control[3]=1.
  - o_write_reg≠0.
  - o_write_reg==rs, or o_write_reg==rt for an instruction that reads rt (R-type, SW, BEQ).
- On stall, ID/EX loads a bubble: o_valid=0, controls=0, o_illegal=0. The instruction is re-presented next cycle, and the hazard clears because the bubble has MemRead=0.
- Flush has priority over stall. When i_flush=1, ID/EX loads a bubble and o_stall is forced to 0.
- When i_valid=0, ID/EX loads a bubble.
- Otherwise ID/EX captures all decoded values on the rising edge: exactly 1-cycle latency, throughput one per cycle.
- Data fields of a bubble are don't-care; control fields and o_valid are 0.
- Branch target uses 32-bit wrap-around addition.
- A write-back and a read to the same register in the same cycle capture the new value (bypass).

Test Plan:
- Reset mid-stream: load ID/EX with a valid LW, then pulse i_rst low asynchronously -> o_valid=0, o_senial_control=0 immediately; register reads return 0.
- Write then read: WB writes $5=0x1234_5678 in the same cycle ADD $3,$5,$0 decodes -> next cycle o_dato1=0x12345678, o_write_reg=3, controls 0x81, alu_op=10. A WB write to $0 leaves $0 reading 0.
- Load-use: LW $2,4($1) then ADD $4,$2,$3 -> one cycle of o_stall=1 with bubble (o_valid=0); ADD then issues the following cycle. SW $2 dependence also stalls. ADDI $4,$0,$2-type (rt as destination) does not stall.
- Extension: ADDI imm 0xFFFC -> o_imm=0xFFFFFFFC. ORI imm 0xFFFC -> o_imm=0x0000FFFC, o_funct=100101. BEQ at pc_plus4=0x100, imm=0xFFFF -> o_branch_target=0xFC.
- Flush with hazard: stall condition plus i_flush=1 -> o_stall=0 and a bubble is registered.
- Illegal opcode 111111 -> next cycle o_illegal=1, controls 0, o_valid=1.

Source files
------------

// File: rtl/id_stage_segmentada.sv
// Pipelined MIPS decode stage: register file with write-first bypass, decode,
// load-use stall, flush and an ID/EX pipeline register (1-cycle latency).
module id_stage_segmentada #(
   parameter int len                  = 32,
   parameter int cantidad_registros   = 32,
   parameter int NB_address_registros = $clog2(cantidad_registros),
   parameter int NB_SENIAL_CONTROL    = 8,
   parameter int NB_ALU_OP            = 2,
   parameter int NB_FUNCT             = 6
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_valid,
   input  logic [len-1:0]                  i_instruccion,
   input  logic [len-1:0]                  i_pc_plus4,
   input  logic                            i_flush,
   input  logic                            i_wb_reg_write,
   input  logic [NB_address_registros-1:0] i_wb_write_reg,
   input  logic [len-1:0]                  i_wb_write_data,
   output logic                            o_stall,
   output logic                            o_valid,
   output logic [len-1:0]                  o_dato1,
   output logic [len-1:0]                  o_dato2,
   output logic [len-1:0]                  o_imm,
   output logic [NB_address_registros-1:0] o_rs,
   output logic [NB_address_registros-1:0] o_rt,
   output logic [NB_address_registros-1:0] o_write_reg,
   output logic [NB_SENIAL_CONTROL-1:0]    o_senial_control,
   output logic [NB_ALU_OP-1:0]            o_alu_op,
   output logic [NB_FUNCT-1:0]             o_funct,
   output logic [len-1:0]                  o_branch_target,
   output logic [len-1:0]                  o_jump_target,
   output logic                            o_illegal
);

   typedef enum logic [1:0] {EXT_NONE, EXT_SIGN, EXT_ZERO} ext_t;

   logic [len-1:0]                  regs [cantidad_registros];
   logic [5:0]                      opcode;
   logic [NB_address_registros-1:0] rs, rt, rd, write_reg;
   logic [15:0]                     imm16;
   logic [len-1:0]                  dato1, dato2, imm, branch_target, jump_target;
   logic [NB_SENIAL_CONTROL-1:0]    ctrl;
   logic [NB_ALU_OP-1:0]            alu_op;
   logic [NB_FUNCT-1:0]             funct;
   ext_t                            ext;
   logic                            illegal, reads_rt, hazard, bubble;

   assign opcode = i_instruccion[31:26];
   assign rs     = i_instruccion[25:21];
   assign rt     = i_instruccion[20:16];
   assign rd     = i_instruccion[15:11];
   assign imm16  = i_instruccion[15:0];

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < cantidad_registros; i++) regs[i] <= '0;
      end else if (i_wb_reg_write && i_wb_write_reg != '0) begin
         regs[i_wb_write_reg] <= i_wb_write_data;
      end
   end

   // Write-first: a same-cycle write-back to the address being read wins.
   always_comb begin
      dato1 = '0;
      dato2 = '0;
      if (rs != '0)
         dato1 = (i_wb_reg_write && i_wb_write_reg == rs) ? i_wb_write_data : regs[rs];
      if (rt != '0)
         dato2 = (i_wb_reg_write && i_wb_write_reg == rt) ? i_wb_write_data : regs[rt];
   end

   always_comb begin
      ctrl     = '0;
      alu_op   = '0;
      ext      = EXT_NONE;
      funct    = i_instruccion[5:0];
      illegal  = 1'b0;
      reads_rt = 1'b0;
      case (opcode)
         6'b000000: begin ctrl = 8'b1000_0001; alu_op = 2'b10; reads_rt = 1'b1; end
         6'b100011: begin ctrl = 8'b1101_1000; ext = EXT_SIGN; end
         6'b101011: begin ctrl = 8'b0110_0000; ext = EXT_SIGN; reads_rt = 1'b1; end
         6'b000100: begin ctrl = 8'b0000_0100; alu_op = 2'b01; ext = EXT_SIGN; reads_rt = 1'b1; end
         6'b001000: begin ctrl = 8'b1100_0000; ext = EXT_SIGN; end
         6'b001100: begin ctrl = 8'b1100_0000; alu_op = 2'b10; ext = EXT_ZERO; funct = 6'b100100; end
         6'b001101: begin ctrl = 8'b1100_0000; alu_op = 2'b10; ext = EXT_ZERO; funct = 6'b100101; end
         6'b000010: begin ctrl = 8'b0000_0010; end
         default:   illegal = 1'b1;
      endcase
   end

   always_comb begin
      case (ext)
         EXT_SIGN: imm = {{(len-16){imm16[15]}}, imm16};
         EXT_ZERO: imm = {{(len-16){1'b0}}, imm16};
         default:  imm = '0;
      endcase
   end

   assign write_reg     = ctrl[0] ? rd : rt;
   assign branch_target = i_pc_plus4 + {{(len-18){imm16[15]}}, imm16, 2'b00};
   assign jump_target   = {i_pc_plus4[len-1:len-4], i_instruccion[25:0], 2'b00};

   // Load in ID/EX whose destination is a source of the instruction now in ID.
   assign hazard = i_valid && o_valid && o_senial_control[3] && o_write_reg != '0 &&
                   (o_write_reg == rs || (reads_rt && o_write_reg == rt));
   assign o_stall = hazard && !i_flush;
   assign bubble  = i_flush || hazard || !i_valid;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_valid          <= 1'b0;
         o_dato1          <= '0;
         o_dato2          <= '0;
         o_imm            <= '0;
         o_rs             <= '0;
         o_rt             <= '0;
         o_write_reg      <= '0;
         o_senial_control <= '0;
         o_alu_op         <= '0;
         o_funct          <= '0;
         o_branch_target  <= '0;
         o_jump_target    <= '0;
         o_illegal        <= 1'b0;
      end else begin
         o_valid          <= !bubble;
         o_dato1          <= dato1;
         o_dato2          <= dato2;
         o_imm            <= imm;
         o_rs             <= rs;
         o_rt             <= rt;
         o_write_reg      <= write_reg;
         o_senial_control <= bubble ? '0 : ctrl;
         o_alu_op         <= bubble ? '0 : alu_op;
         o_funct          <= funct;
         o_branch_target  <= branch_target;
         o_jump_target    <= jump_target;
         o_illegal        <= bubble ? 1'b0 : illegal;
      end
   end

endmodule

// File: tb/tb_id_stage_segmentada.sv
// Directed bench for id_stage_segmentada: expected ID/EX contents are queued at
// issue time and checked by a monitor whenever o_valid is presented.
module tb_id_stage_segmentada;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  wr;
      logic [7:0]  ctrl;
      logic [1:0]  alu;
      logic [5:0]  funct;
      logic [31:0] bt;
      logic [31:0] jt;
      logic        ill;
   } exp_t;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic [31:0] i_instruccion;
   logic [31:0] i_pc_plus4;
   logic        i_flush;
   logic        i_wb_reg_write;
   logic [4:0]  i_wb_write_reg;
   logic [31:0] i_wb_write_data;
   logic        o_stall, o_valid, o_illegal;
   logic [31:0] o_dato1, o_dato2, o_imm, o_branch_target, o_jump_target;
   logic [4:0]  o_rs, o_rt, o_write_reg;
   logic [7:0]  o_senial_control;
   logic [1:0]  o_alu_op;
   logic [5:0]  o_funct;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   id_stage_segmentada dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_instruccion(i_instruccion),
      .i_pc_plus4(i_pc_plus4), .i_flush(i_flush), .i_wb_reg_write(i_wb_reg_write),
      .i_wb_write_reg(i_wb_write_reg), .i_wb_write_data(i_wb_write_data),
      .o_stall(o_stall), .o_valid(o_valid), .o_dato1(o_dato1), .o_dato2(o_dato2),
      .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt), .o_write_reg(o_write_reg),
      .o_senial_control(o_senial_control), .o_alu_op(o_alu_op), .o_funct(o_funct),
      .o_branch_target(o_branch_target), .o_jump_target(o_jump_target), .o_illegal(o_illegal)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc4,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic [4:0] wr,
                               input logic [7:0] ctrl, input logic [1:0] alu,
                               input logic [5:0] funct, input logic ill);
      exp_t e;
      logic signed [31:0] off;
      off     = 32'($signed(instr[15:0]));
      e.d1    = d1;
      e.d2    = d2;
      e.imm   = imm;
      e.rs    = instr[25:21];
      e.rt    = instr[20:16];
      e.wr    = wr;
      e.ctrl  = ctrl;
      e.alu   = alu;
      e.funct = funct;
      e.bt    = pc4 + 32'(off * 4);
      e.jt    = (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
      e.ill   = ill;
      return e;
   endfunction

   // One ID cycle: drive at negedge, check o_stall, queue the expected capture.
   task automatic drive(input logic [31:0] instr, input logic [31:0] pc4, input logic valid,
                        input logic flush, input logic wb_en, input logic [4:0] wb_addr,
                        input logic [31:0] wb_data, input logic exp_stall,
                        input logic push, input exp_t e);
      i_instruccion   = instr;
      i_pc_plus4      = pc4;
      i_valid         = valid;
      i_flush         = flush;
      i_wb_reg_write  = wb_en;
      i_wb_write_reg  = wb_addr;
      i_wb_write_data = wb_data;
      #1;
      check("stall", 32'(o_stall), 32'(exp_stall));
      if (push) exp_q.push_back(e);
      @(negedge i_clk);
   endtask

   task automatic check_bubble(input string name);
      check({name, "_valid"}, 32'(o_valid), 32'd0);
      check({name, "_ctrl"}, 32'(o_senial_control), 32'd0);
      check({name, "_illegal"}, 32'(o_illegal), 32'd0);
   endtask

   always @(posedge i_clk) begin
      #1;
      if (o_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(o_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("dato1", o_dato1, e.d1);
            check("dato2", o_dato2, e.d2);
            check("imm", o_imm, e.imm);
            check("rs", 32'(o_rs), 32'(e.rs));
            check("rt", 32'(o_rt), 32'(e.rt));
            check("write_reg", 32'(o_write_reg), 32'(e.wr));
            check("ctrl", 32'(o_senial_control), 32'(e.ctrl));
            check("alu_op", 32'(o_alu_op), 32'(e.alu));
            check("funct", 32'(o_funct), 32'(e.funct));
            check("branch_target", o_branch_target, e.bt);
            check("jump_target", o_jump_target, e.jt);
            check("illegal", 32'(o_illegal), 32'(e.ill));
         end
      end
   end

   initial begin
      exp_t nx;
      nx = '0;
      i_rst = 1'b0; i_valid = 1'b0; i_instruccion = '0; i_pc_plus4 = '0; i_flush = 1'b0;
      i_wb_reg_write = 1'b0; i_wb_write_reg = '0; i_wb_write_data = '0;
      repeat (2) @(negedge i_clk);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_ctrl", 32'(o_senial_control), 32'd0);
      check("rst_stall", 32'(o_stall), 32'd0);
      check("rst_dato1", o_dato1, 32'd0);
      i_rst = 1'b1;

      // bypass, $0 protection, extension
      drive(32'h00A01820, 32'h4, 1, 0, 1, 5'd5, 32'h1234_5678, 0, 1,
            mk(32'h00A01820, 32'h4, 32'h1234_5678, 0, 0, 5'd3, 8'h81, 2'b10, 6'h20, 0));
      drive(32'h00053020, 32'h8, 1, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, 1,
            mk(32'h00053020, 32'h8, 0, 32'h1234_5678, 0, 5'd6, 8'h81, 2'b10, 6'h20, 0));
      drive(32'h2007FFFC, 32'hC, 1, 0, 1, 5'd1, 32'h0000_0100, 0, 1,
            mk(32'h2007FFFC, 32'hC, 0, 0, 32'hFFFF_FFFC, 5'd7, 8'hC0, 2'b00, 6'h3C, 0));
      // load-use on rs
      drive(32'h8C220004, 32'h10, 1, 0, 1, 5'd3, 32'h0000_0055, 0, 1,
            mk(32'h8C220004, 32'h10, 32'h100, 0, 32'h4, 5'd2, 8'hD8, 2'b00, 6'h04, 0));
      drive(32'h00432020, 32'h14, 1, 0, 1, 5'd2, 32'h0000_AAAA, 1, 0, nx);
      check_bubble("stall_bubble");
      drive(32'h00432020, 32'h14, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'h00432020, 32'h14, 32'hAAAA, 32'h55, 0, 5'd4, 8'h81, 2'b10, 6'h20, 0));
      // load-use on SW rt
      drive(32'h8C220008, 32'h18, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'h8C220008, 32'h18, 32'h100, 32'hAAAA, 32'h8, 5'd2, 8'hD8, 2'b00, 6'h08, 0));
      drive(32'hAC220000, 32'h1C, 1, 0, 0, 5'd0, 0, 1, 0, nx);
      check_bubble("sw_bubble");
      drive(32'hAC220000, 32'h1C, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'hAC220000, 32'h1C, 32'h100, 32'hAAAA, 0, 5'd2, 8'h60, 2'b00, 6'h00, 0));
      // ADDI writing the load's destination does not stall
      drive(32'h8C22000C, 32'h20, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'h8C22000C, 32'h20, 32'h100, 32'hAAAA, 32'hC, 5'd2, 8'hD8, 2'b00, 6'h0C, 0));
      drive(32'h20020007, 32'h24, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'h20020007, 32'h24, 0, 32'hAAAA, 32'h7, 5'd2, 8'hC0, 2'b00, 6'h07, 0));
      drive(32'h3408FFFC, 32'h28, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'h3408FFFC, 32'h28, 0, 0, 32'h0000_FFFC, 5'd8, 8'hC0, 2'b10, 6'h25, 0));
      drive(32'h30298001, 32'h2C, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'h30298001, 32'h2C, 32'h100, 0, 32'h0000_8001, 5'd9, 8'hC0, 2'b10, 6'h24, 0));
      drive(32'h1022FFFF, 32'h100, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'h1022FFFF, 32'h100, 32'h100, 32'hAAAA, 32'hFFFF_FFFF, 5'd2, 8'h04, 2'b01, 6'h3F, 0));
      check("beq_target_const", mk(32'h1022FFFF, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0).bt, 32'hFC);
      drive(32'h08000040, 32'h3000_0104, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'h08000040, 32'h3000_0104, 0, 0, 0, 5'd0, 8'h02, 2'b00, 6'h00, 0));
      drive(32'hFC000000, 32'h108, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'hFC000000, 32'h108, 0, 0, 0, 5'd0, 8'h00, 2'b00, 6'h00, 1));
      // flush beats a pending load-use stall
      drive(32'h8C220000, 32'h10C, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'h8C220000, 32'h10C, 32'h100, 32'hAAAA, 0, 5'd2, 8'hD8, 2'b00, 6'h00, 0));
      drive(32'h00432020, 32'h110, 1, 1, 0, 5'd0, 0, 0, 0, nx);
      check_bubble("flush_bubble");
      drive(32'h00432020, 32'h110, 0, 0, 0, 5'd0, 0, 0, 0, nx);
      check_bubble("invalid_bubble");
      // asynchronous reset mid-stream
      drive(32'h8C220004, 32'h114, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'h8C220004, 32'h114, 32'h100, 32'hAAAA, 32'h4, 5'd2, 8'hD8, 2'b00, 6'h04, 0));
      i_valid = 1'b0;
      #2 i_rst = 1'b0;
      #1;
      check("arst_valid", 32'(o_valid), 32'd0);
      check("arst_ctrl", 32'(o_senial_control), 32'd0);
      check("arst_stall", 32'(o_stall), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b1;
      drive(32'h00A11820, 32'h4, 1, 0, 0, 5'd0, 0, 0, 1,
            mk(32'h00A11820, 32'h4, 0, 0, 0, 5'd3, 8'h81, 2'b10, 6'h20, 0));
      i_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
